// File: rtl/pixel_tx_scheduler.sv
// pixel_tx_scheduler
// Packet FIFO shared by the pixel stream (high priority, ready/valid) and
// coalesced cursor-position updates (low priority, forced in after a run of
// pixel grants). The I2C slave reads the head and pops it when a read ends.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   pix_valid/x/y/colour  pixel packet offer, held until pix_ready
//   pix_ready             pixel accepted this cycle (may follow out_pop)
//   cur_req/x/y           single-cycle cursor update, latest wins
//   out_valid             FIFO non-empty, head fields valid
//   out_x/y/status        head entry; status[7]=cursor, [2:0]=colour
//   out_pop               head consumed (ignored while empty)
//   level                 occupancy 0..DEPTH
module pixel_tx_scheduler #(
  parameter int DEPTH        = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid,
  input  logic [7:0] pix_x,
  input  logic [7:0] pix_y,
  input  logic [2:0] pix_colour,
  output logic       pix_ready,
  input  logic       cur_req,
  input  logic [7:0] cur_x,
  input  logic [7:0] cur_y,
  output logic       out_valid,
  output logic [7:0] out_x,
  output logic [7:0] out_y,
  output logic [7:0] out_status,
  input  logic       out_pop,
  output logic [4:0] level
);

  localparam int         PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_LVL = 5'(DEPTH);
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  // Entry layout: {type, x[7:0], y[7:0], colour[2:0]}
  logic [19:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [4:0]       level_reg, level_next;
  logic             pending_reg, pending_next;
  logic [7:0]       pend_x_reg, pend_y_reg;
  logic [3:0]       starve_reg, starve_next;

  logic        empty, full, pop, can_accept, forced;
  logic        push_cur, push_pix, push;
  logic [19:0] wr_entry, head;

  always_comb begin
    empty      = (level_reg == 5'd0);
    full       = (level_reg == DEPTH_LVL);
    pop        = out_pop && !empty;
    // A pop this cycle frees the slot the push lands in, so full+pop accepts.
    can_accept = !full || pop;
    forced     = pending_reg && (starve_reg >= LIMIT);
    push_cur   = can_accept && pending_reg && (forced || !pix_valid);
    push_pix   = can_accept && pix_valid && !forced;
    push       = push_cur || push_pix;
    pix_ready  = can_accept && !forced;
    wr_entry   = push_cur ? {1'b1, pend_x_reg, pend_y_reg, 3'b000}
                          : {1'b0, pix_x, pix_y, pix_colour};
  end

  always_comb begin
    // A new request always leaves an update pending, even when the previous
    // one is being written this very cycle.
    pending_next = pending_reg;
    if (cur_req)
      pending_next = 1'b1;
    else if (push_cur)
      pending_next = 1'b0;

    starve_next = starve_reg;
    if (push_cur || !pending_reg)
      starve_next = 4'd0;
    else if (push_pix && starve_reg != 4'hF)
      starve_next = starve_reg + 4'd1;

    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 5'd1;
      2'b01:   level_next = level_reg - 5'd1;
      default: level_next = level_reg;
    endcase
  end

  // Storage array carries no reset; stale words are masked by level.
  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr_reg] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      pending_reg <= 1'b0;
      pend_x_reg  <= '0;
      pend_y_reg  <= '0;
      starve_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg   <= level_next;
      pending_reg <= pending_next;
      starve_reg  <= starve_next;
      if (cur_req) begin
        pend_x_reg <= cur_x;
        pend_y_reg <= cur_y;
      end
    end
  end

  // First-word fall-through head view, forced to zero while empty.
  always_comb begin
    head       = mem[rd_ptr_reg];
    out_valid  = !empty;
    out_x      = empty ? 8'd0 : head[18:11];
    out_y      = empty ? 8'd0 : head[10:3];
    out_status = empty ? 8'd0 : {head[19], 4'b0000, head[2:0]};
    level      = level_reg;
  end

endmodule

// File: tb/tb_pixel_tx_scheduler.sv
// Bench for pixel_tx_scheduler: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue model.
module tb_pixel_tx_scheduler;

  localparam int DEPTH = 8;
  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_x = '0;
  logic [7:0] pix_y = '0;
  logic [2:0] pix_colour = '0;
  logic       pix_ready;
  logic       cur_req = 1'b0;
  logic [7:0] cur_x = '0;
  logic [7:0] cur_y = '0;
  logic       out_valid;
  logic [7:0] out_x, out_y, out_status;
  logic       out_pop = 1'b0;
  logic [4:0] level;

  pixel_tx_scheduler #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_colour(pix_colour), .pix_ready(pix_ready),
    .cur_req(cur_req), .cur_x(cur_x), .cur_y(cur_y),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .out_status(out_status), .out_pop(out_pop), .level(level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [19:0] q[$];
  bit          m_pend = 1'b0;
  logic [7:0]  m_px = '0, m_py = '0;
  int          m_starve = 0;
  bit          live = 1'b0;
  int          m_sz;
  bit          m_pop, m_acc, m_frc, m_cpush, m_ppush;
  logic [19:0] m_e;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_pend   = 1'b0;
      m_starve = 0;
      live     = 1'b1;
    end else if (live) begin
      m_sz    = q.size();
      m_pop   = out_pop && (m_sz > 0);
      m_acc   = (m_sz < DEPTH) || m_pop;
      m_frc   = m_pend && (m_starve >= LIMIT);
      m_cpush = m_acc && m_pend && (m_frc || !pix_valid);
      m_ppush = m_acc && pix_valid && !m_frc;
      if (m_pop) begin
        m_e = q.pop_front();
        $display("pop  x=%0d y=%0d status=0x%02h", m_e[18:11], m_e[10:3],
                 {m_e[19], 4'b0000, m_e[2:0]});
      end
      if (m_cpush)
        q.push_back({1'b1, m_px, m_py, 3'b000});
      else if (m_ppush)
        q.push_back({1'b0, pix_x, pix_y, pix_colour});
      if (m_cpush)
        m_starve = 0;
      else if (m_ppush && m_pend)
        m_starve = (m_starve < 15) ? m_starve + 1 : 15;
      if (cur_req) begin
        m_pend = 1'b1;
        m_px   = cur_x;
        m_py   = cur_y;
      end else if (m_cpush) begin
        m_pend = 1'b0;
      end
      if (!m_pend)
        m_starve = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [19:0] c_e;
  int          c_sz;
  always @(negedge clk) begin
    if (live) begin
      c_sz = q.size();
      c_e  = (c_sz > 0) ? q[0] : 20'd0;
      chk("level", int'(level), c_sz);
      chk("out_valid", int'(out_valid), int'(c_sz > 0));
      chk("out_x", int'(out_x), int'(c_e[18:11]));
      chk("out_y", int'(out_y), int'(c_e[10:3]));
      chk("out_status", int'(out_status), int'({c_e[19], 4'b0000, c_e[2:0]}));
      chk("pix_ready", int'(pix_ready),
          int'(((c_sz < DEPTH) || (out_pop && c_sz > 0)) && !(m_pend && m_starve >= LIMIT)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] ready_hist;
  int         n_cur, cur_seen_x, cur_seen_y, cur_seen_st;
  bit         accepted;

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("reset_level", int'(level), 0);
    chk("reset_valid", int'(out_valid), 0);

    // Two pixels, then pop them one at a time.
    pix_valid = 1'b1; pix_x = 8'd1; pix_y = 8'd2; pix_colour = 3'd5;
    tick();
    pix_x = 8'd3; pix_y = 8'd4; pix_colour = 3'd2;
    tick();
    pix_valid = 1'b0;
    #1;
    chk("two_level", int'(level), 2);
    chk("two_head_x", int'(out_x), 1);
    chk("two_head_y", int'(out_y), 2);
    chk("two_head_st", int'(out_status), 8'h05);
    out_pop = 1'b1;
    tick();
    out_pop = 1'b0;
    #1;
    chk("pop1_x", int'(out_x), 3);
    chk("pop1_y", int'(out_y), 4);
    chk("pop1_st", int'(out_status), 8'h02);
    out_pop = 1'b1;
    tick();
    out_pop = 1'b0;
    #1;
    chk("pop2_valid", int'(out_valid), 0);
    chk("pop2_level", int'(level), 0);

    // Fill to DEPTH, 9th offer stalls until a pop frees a slot.
    pix_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      pix_x = 8'(k); pix_y = 8'(k + 100); pix_colour = 3'(k);
      tick();
    end
    pix_x = 8'd9; pix_y = 8'd109; pix_colour = 3'd1;
    #1;
    chk("full_ready", int'(pix_ready), 0);
    chk("full_level", int'(level), 8);
    out_pop = 1'b1;
    #1;
    chk("full_pop_ready", int'(pix_ready), 1);
    tick();
    chk("full_pop_level", int'(level), 8);
    chk("full_pop_head", int'(out_x), 2);
    for (int k = 10; k <= 16; k++) begin
      pix_x = 8'(k); pix_y = 8'(k + 100); pix_colour = 3'(k);
      tick();
    end
    pix_valid = 1'b0;
    for (int k = 9; k <= 16; k++) begin
      #1;
      chk("wrap_order", int'(out_x), k);
      out_pop = 1'b1;
      tick();
    end
    out_pop = 1'b0;
    #1;
    chk("wrap_empty", int'(out_valid), 0);

    // Coalescing: two requests under continuous pixel traffic.
    pix_valid = 1'b1; pix_x = 8'd200; pix_y = 8'd201; pix_colour = 3'd3;
    out_pop = 1'b1;
    cur_req = 1'b1; cur_x = 8'd10; cur_y = 8'd20;
    tick();
    cur_x = 8'd30; cur_y = 8'd40;
    tick();
    cur_req = 1'b0;
    n_cur = 0; cur_seen_x = 0; cur_seen_y = 0; cur_seen_st = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (out_valid && out_status[7]) begin
        n_cur++;
        cur_seen_x = int'(out_x); cur_seen_y = int'(out_y); cur_seen_st = int'(out_status);
      end
      tick();
    end
    chk("coal_count", n_cur, 1);
    chk("coal_x", cur_seen_x, 30);
    chk("coal_y", cur_seen_y, 40);
    chk("coal_status", cur_seen_st, 8'h80);

    // Starvation: four pixel grants, one forced cursor cycle, pixels resume.
    cur_req = 1'b1; cur_x = 8'd55; cur_y = 8'd66;
    tick();
    cur_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      ready_hist[i] = pix_ready;
      tick();
    end
    chk("starve_pattern", int'(ready_hist), 8'hEF);

    // Idle cursor update.
    pix_valid = 1'b0;
    out_pop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!out_valid) break;
      tick();
    end
    chk("drain_empty", int'(out_valid), 0);
    out_pop = 1'b0;
    cur_req = 1'b1; cur_x = 8'd7; cur_y = 8'd9;
    tick();
    cur_req = 1'b0;
    #1;
    chk("idle_cur_early", int'(out_valid), 0);
    tick();
    chk("idle_cur_valid", int'(out_valid), 1);
    chk("idle_cur_x", int'(out_x), 7);
    chk("idle_cur_y", int'(out_y), 9);
    chk("idle_cur_st", int'(out_status), 8'h80);
    out_pop = 1'b1;
    tick();
    out_pop = 1'b0;

    // Reset with level 5 and a cursor update pending.
    pix_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pix_x = 8'(k + 40); pix_y = 8'(k + 50); pix_colour = 3'(k);
      tick();
    end
    pix_x = 8'd44; cur_req = 1'b1; cur_x = 8'd77; cur_y = 8'd88;
    tick();
    cur_req = 1'b0;
    #1;
    chk("prerst_level", int'(level), 5);
    rst = 1'b1; cur_req = 1'b1;
    tick();
    rst = 1'b0; cur_req = 1'b0; pix_valid = 1'b0;
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_x", int'(out_x), 0);
    chk("rst_y", int'(out_y), 0);
    chk("rst_status", int'(out_status), 0);
    repeat (10) tick();
    chk("rst_no_stale", int'(out_valid), 0);

    // Randomized traffic.
    accepted = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!pix_valid || accepted) begin
        pix_valid  = ($urandom_range(0, 3) != 0);
        pix_x      = 8'($urandom);
        pix_y      = 8'($urandom);
        pix_colour = 3'($urandom);
      end
      cur_req = ($urandom_range(0, 7) == 0);
      cur_x   = 8'($urandom);
      cur_y   = 8'($urandom);
      out_pop = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 299) == 0);
      #1;
      accepted = pix_valid && pix_ready && !rst;
      tick();
    end
    rst = 1'b0; pix_valid = 1'b0; cur_req = 1'b0; out_pop = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_tx_scheduler.md
Name: pixel_tx_scheduler

Overview:
Buffers and schedules drawing packets bound for the I2C readout path. Two requesters share one packet FIFO:
- the pixel stream from the packet generator (high priority, with a ready/valid handshake);
- cursor-position updates (low priority, coalesced, with starvation protection).

The I2C slave reads the FIFO head and pops it when a read transaction completes. This decouples bursty brush/symmetry expansion from the slow bus.

Parameters:
DEPTH, 8, FIFO entries; power of two, range 2..16.
STARVE_LIMIT, 4, consecutive pixel-granted cycles a pending cursor update tolerates before it is forced in; range 1..15.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
pix_valid  input  1  pixel packet offered; held stable until accepted.
pix_x  input  8  pixel X.
pix_y  input  8  pixel Y.
pix_colour  input  3  pixel RGB.
pix_ready  output  1  pixel accepted this cycle when pix_valid && pix_ready.
cur_req  input  1  single-cycle cursor-update request.
cur_x  input  8  cursor X, sampled with cur_req.
cur_y  input  8  cursor Y, sampled with cur_req.
out_valid  output  1  FIFO non-empty; head fields valid.
out_x  output  8  head X.
out_y  output  8  head Y.
out_status  output  8  head status: [7] = type (1 = cursor, 0 = pixel); [6:3] = 0; [2:0] = colour (0 for cursor).
out_pop  input  1  I2C consumed the head; ignored when out_valid = 0.
level  output  5  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset, synchronous on rst high: FIFO empty, level = 0, out_valid = 0, out_x/out_y/out_status = 0, cursor pending cleared, starvation counter = 0. Reset overrides every concurrent input, including mid-burst.
- FIFO storage:
  - Each entry is {type, x, y, colour}, 20 bits.
  - Separate write and read pointers, log2(DEPTH) bits, wrapping modulo DEPTH; occupancy is tracked by a counter.
  - full = (level == DEPTH); empty = (level == 0).
- Head output: registered-read or combinational view of the entry at the read pointer; valid in the same cycle out_valid is high. When empty, the out_x/out_y/out_status values do not matter, but are driven 0.
- Pop: when out_pop && out_valid, the read pointer advances and level decrements on the next edge.
- Cursor pending register:
  - cur_req loads cur_x/cur_y and sets pending. The latest request wins; this overwrites an older pending update without queueing.
  - If cur_req arrives in the same cycle the pending entry is written to the FIFO, the new coordinates stay pending (pending remains 1).
- Arbitration, evaluated each cycle the FIFO can accept (not full, or full with a pop this cycle):
  1. forced = pending && (starve_cnt >= STARVE_LIMIT).
  2. If forced: push the cursor entry, pix_ready = 0, clear pending, starve_cnt = 0.
  3. Else if pix_valid: push the pixel, pix_ready = 1. If pending, starve_cnt increments, saturating at 15.
  4. Else if pending: push the cursor entry, clear pending, starve_cnt = 0.
  5. starve_cnt resets to 0 whenever pending = 0.
- Full: pix_ready = 0 unless a pop occurs this cycle. pix_ready may depend combinationally on out_pop. No cursor push happens while full without a pop. Pending is retained and never dropped.
- Simultaneous push and pop: both take effect and level is unchanged. This is legal when full, and yields a pointer wrap without corruption.
- Simultaneous push and pop when empty: the pop is ignored because out_valid = 0. The push lands and out_valid rises the next cycle.
- Latency: a packet accepted at edge N appears on out_* with out_valid = 1 after edge N (first-word fall-through, one cycle).
- At most one push per cycle.
- Ordering: packets leave in strict FIFO order.

Test Plan:
- Reset, then push pixels (1,2,c=5), (3,4,c=2) with out_pop held 0. Required: level = 2; head = x1 y2 status 0x05. After one pop: head = x3 y4 status 0x02. After a second pop: out_valid = 0, level = 0.
- Fill to DEPTH = 8 with continuous pix_valid. Required: pix_ready = 0 on the 9th offer and level = 8. Pulsing out_pop then accepts the 9th pixel in that same cycle while level stays 8, and wrap-around ordering is preserved across 16 packets.
- Coalescing: cur_req (10,20) then cur_req (30,40) while pix_valid is held continuously. Required: only one cursor entry, x30 y40 status 0x80.
- Starvation, STARVE_LIMIT = 4: hold pix_valid with cursor pending. Required: exactly 4 pixels are accepted, then 1 cycle with pix_ready = 0 and the cursor entry pushed, then pixels resume.
- Idle cursor: pix_valid = 0 and cur_req (7,9). Required: the cursor entry appears on out_* 2 cycles after the cur_req edge.
- Assert rst for 1 cycle with level = 5 and pending set. Required: next cycle level = 0, out_valid = 0, out_x/out_y/out_status = 0, and no stale cursor entry is ever emitted.
